r5p_gpr_mp: RTL and testbench
=============================

Name: r5p_gpr_mp

Overview:
Multi-port general purpose register file with an integrated writeback scoreboard, for superscalar and pipelined R5P cores. It provides NR combinational read ports and NW synchronous write ports. Each register has a pending-write counter: issue logic locks a destination register, and writeback retires the lock, so hazards are visible as a per-read-port busy flag. x0 is hardwired to zero and is never busy.

Parameters:
AW, 5, register address width (4 for RV32E)
XLEN, 32, register data width
NR, 2, number of read ports (1..8)
NW, 1, number of write ports (1..4)
NL, 1, number of lock ports (1..4)
CW, 2, pending-write counter width per register (up to 2**CW-1 outstanding writes)
WBYP, 1'b1, same-cycle write-to-read bypass enable

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
r_e  input  NR  read enable per port (qualifies r_busy only)
r_a  input  NR*AW  read addresses, port i at [i*AW+:AW]
r_d  output  NR*XLEN  read data, port i at [i*XLEN+:XLEN]
r_busy  output  NR  read port i addresses a register with a pending write
w_e  input  NW  write enable per port
w_a  input  NW*AW  write addresses
w_d  input  NW*XLEN  write data
l_e  input  NL  lock request: increment the pending count of l_a
l_a  input  NL*AW  lock addresses
l_rdy  output  NL  lock port can accept (target counter not saturated)
err  output  1  sticky: a write retired a register whose counter was 0

Behaviour:
- Reset (rst=0, async): all registers clear to 0; all counters clear to 0; err clears to 0. With all inputs idle, outputs are r_d=0, r_busy=0, l_rdy=all ones.
- Storage is flops, so the reset clear is legal. Writes take effect on the rising clk edge; reads are combinational (0-cycle latency).
- x0 behaviour:
  - Writes and locks to address 0 are ignored.
  - Reads of address 0 return 0 and r_busy=0.
  - l_rdy=1 for address 0.
  - A write to address 0 never sets err.
- Write port priority: if several write ports hit the same address in one cycle, the highest-index port's data is stored.
- Counter update per register, per cycle: next = cnt + (number of accepted locks to that register) - (number of write ports writing it).
  - A lock is accepted when l_e & l_rdy.
  - The decrement saturates at 0; any underflow sets err.
  - A simultaneous accepted lock and write to the same register leaves the count unchanged.
- l_rdy[j] = 0 when cnt[l_a[j]] plus the accepted locks from lower-index lock ports to the same address would exceed 2**CW-1. Same-cycle writes to that register are not credited. l_rdy is combinational from l_a and state.
- r_busy[i] = r_e[i] & (a_i != 0) & (effective_cnt != 0).
  - WBYP=1: effective_cnt = cnt minus the same-cycle writes to a_i, floored at 0.
  - WBYP=0: effective_cnt = cnt.
  - Same-cycle locks never affect r_busy.
- r_d[i]:
  - WBYP=1 and any write port writing a_i (a_i != 0) this cycle: the highest-index such port's w_d.
  - Otherwise: the stored value.
- err: set on the clock edge after an underflow; cleared only by reset.
- Reset asserted mid-operation clears all pending counters immediately. Writebacks still in flight then set err, and the bench must expect this.

Test Plan:
- Reset, then read x1..x31 on both ports -> r_d=0, r_busy=0, l_rdy=1, err=0.
- Lock x5, then 3 cycles later write x5=0xDEADBEEF while reading x5 (WBYP=1) -> r_busy=1 for the 3 cycles; bypass cycle gives r_d=0xDEADBEEF, r_busy=0; next cycle stored value 0xDEADBEEF.
- Lock x7 three times (CW=2), fourth lock -> l_rdy=0 and the count holds at 3; one write to x7 -> l_rdy=1; lock and write x7 in the same cycle -> count unchanged at 2.
- NW=2: both ports write x9 (0x11, 0x22) in the same cycle -> stored 0x22; bypass read returns 0x22; an outstanding count of 2 drops to 0.
- Write x0=0xFFFFFFFF and lock x0 -> r_d(x0)=0, r_busy=0, l_rdy=1, err=0. Write x3 with count 0 -> data stored, err=1 from the next cycle, held until rst.
- Lock x4, assert rst mid-lock -> count cleared, r_busy=0; a later write to x4 stores data and sets err=1.

Source files
------------

// File: rtl/r5p_gpr_mp.sv
// Multi-port GPR file with per-register pending-write counters.
// Locks raise a register's count, writebacks retire it; reads flag hazards.
module r5p_gpr_mp #(
  parameter int   AW   = 5,
  parameter int   XLEN = 32,
  parameter int   NR   = 2,
  parameter int   NW   = 1,
  parameter int   NL   = 1,
  parameter int   CW   = 2,
  parameter logic WBYP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR-1:0]      r_e,
  input  logic [NR*AW-1:0]   r_a,
  output logic [NR*XLEN-1:0] r_d,
  output logic [NR-1:0]      r_busy,
  input  logic [NW-1:0]      w_e,
  input  logic [NW*AW-1:0]   w_a,
  input  logic [NW*XLEN-1:0] w_d,
  input  logic [NL-1:0]      l_e,
  input  logic [NL*AW-1:0]   l_a,
  output logic [NL-1:0]      l_rdy,
  output logic               err
);

  localparam int NREG = 2**AW;
  localparam int SW   = CW + 3;
  localparam logic [SW-1:0] CMAX = SW'((2**CW) - 1);

  logic [XLEN-1:0] gpr     [NREG];
  logic [CW-1:0]   cnt     [NREG];
  logic [CW-1:0]   cnt_nxt [NREG];
  logic [NREG-1:0] uflow;
  logic [NL-1:0]   rdy;

  // lower-index accepted locks to the same address count against the limit
  always_comb begin
    logic [SW-1:0] acc;
    rdy = '0;
    acc = '0;
    for (int j = 0; j < NL; j++) begin
      acc = SW'(cnt[l_a[j*AW+:AW]]);
      for (int k = 0; k < j; k++) begin
        if (l_e[k] && rdy[k] &&
            l_a[k*AW+:AW] == l_a[j*AW+:AW])
          acc = acc + SW'(1);
      end
      rdy[j] = (l_a[j*AW+:AW] == '0) || (acc < CMAX);
    end
  end

  assign l_rdy = rdy;

  always_comb begin
    logic [SW-1:0] inc;
    logic [SW-1:0] dec;
    logic [SW-1:0] sum;
    uflow = '0;
    inc   = '0;
    dec   = '0;
    sum   = '0;
    for (int r = 0; r < NREG; r++) begin
      inc = '0;
      dec = '0;
      for (int j = 0; j < NL; j++)
        if (l_e[j] && rdy[j] && l_a[j*AW+:AW] == AW'(r))
          inc = inc + SW'(1);
      for (int i = 0; i < NW; i++)
        if (w_e[i] && w_a[i*AW+:AW] == AW'(r))
          dec = dec + SW'(1);
      sum = SW'(cnt[r]) + inc;
      if (r == 0) begin
        cnt_nxt[r] = '0;
      end else if (sum < dec) begin
        cnt_nxt[r] = '0;
        uflow[r]   = 1'b1;
      end else begin
        cnt_nxt[r] = CW'(sum - dec);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        gpr[r] <= '0;
        cnt[r] <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        for (int i = 0; i < NW; i++)
          if (w_e[i] && w_a[i*AW+:AW] == AW'(r))
            gpr[r] <= w_d[i*XLEN+:XLEN];
        cnt[r] <= cnt_nxt[r];
      end
      err <= err | (|uflow);
    end
  end

  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic [SW-1:0]   wn;
    logic [SW-1:0]   ec;
    r_d    = '0;
    r_busy = '0;
    a      = '0;
    d      = '0;
    wn     = '0;
    ec     = '0;
    for (int i = 0; i < NR; i++) begin
      a  = r_a[i*AW+:AW];
      d  = gpr[a];
      wn = '0;
      for (int k = 0; k < NW; k++) begin
        if (WBYP && w_e[k] && w_a[k*AW+:AW] == a) begin
          d  = w_d[k*XLEN+:XLEN];
          wn = wn + SW'(1);
        end
      end
      ec = SW'(cnt[a]);
      ec = (ec > wn) ? ec - wn : '0;
      if (a == '0) d = '0;
      r_d[i*XLEN+:XLEN] = d;
      r_busy[i] = r_e[i] && (a != '0) && (ec != '0);
    end
  end

endmodule

// File: tb/tb_r5p_gpr_mp.sv
// Directed scoreboard bench for r5p_gpr_mp (NR=2, NW=2, NL=2).
// Expected values are queued at drive time and popped at each check.
module tb_r5p_gpr_mp;

  localparam int AW = 5;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    r_e;
  logic [9:0]    r_a;
  logic [63:0]   r_d;
  logic [1:0]    r_busy;
  logic [1:0]    w_e;
  logic [9:0]    w_a;
  logic [63:0]   w_d;
  logic [1:0]    l_e;
  logic [9:0]    l_a;
  logic [1:0]    l_rdy;
  logic          err;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q [$];

  r5p_gpr_mp #(
    .AW(AW), .XLEN(XL), .NR(2), .NW(2),
    .NL(2), .CW(2), .WBYP(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .r_e(r_e), .r_a(r_a), .r_d(r_d), .r_busy(r_busy),
    .w_e(w_e), .w_a(w_a), .w_d(w_d),
    .l_e(l_e), .l_a(l_a), .l_rdy(l_rdy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    r_e = '0; r_a = '0;
    w_e = '0; w_a = '0; w_d = '0;
    l_e = '0; l_a = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] ex;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      ex = exp_q.pop_front();
      assert (obs === ex) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
      end
    end
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    r_e = 2'b11;
    r_a = {a1, a0};
  endtask

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) tick();
    #2;
    push(64'd0);  chk("rst_err", 64'(err));
    push(64'd3);  chk("rst_lrdy", 64'(l_rdy));
    push(64'd0);  chk("rst_busy", 64'(r_busy));
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int a = 1; a < 32; a++) begin
      rd(5'(a), 5'(a));
      #2;
      push(64'd0); chk("init_rd", r_d);
      push(64'd0); chk("init_busy", 64'(r_busy));
      tick();
    end
    push(64'd3); chk("init_lrdy", 64'(l_rdy));
    push(64'd0); chk("init_err", 64'(err));

    // lock x5, three busy cycles, then bypassed write
    idle();
    l_e = 2'b01; l_a = 10'd5;
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      rd(5'd5, 5'd5);
      #2;
      push(64'd3); chk("x5_busy", 64'(r_busy));
      tick();
    end
    rd(5'd5, 5'd5);
    w_e = 2'b01; w_a = 10'd5; w_d = {32'd0, 32'hDEADBEEF};
    #2;
    push({2{32'hDEADBEEF}}); chk("x5_byp_d", r_d);
    push(64'd0);             chk("x5_byp_busy", 64'(r_busy));
    tick();
    idle();
    rd(5'd5, 5'd5);
    #2;
    push({2{32'hDEADBEEF}}); chk("x5_stored", r_d);
    push(64'd0);             chk("x5_busy_after", 64'(r_busy));
    tick();

    // saturate x7
    idle();
    for (int c = 0; c < 3; c++) begin
      l_e = 2'b01; l_a = 10'd7;
      #2;
      push(64'd1); chk("x7_lrdy_ok", 64'(l_rdy[0]));
      tick();
    end
    l_e = 2'b01; l_a = {5'd7, 5'd7};
    #2;
    push(64'd0); chk("x7_lrdy_full", 64'(l_rdy));
    tick();
    idle();
    l_a = {5'd7, 5'd7};
    w_e = 2'b01; w_a = 10'd7; w_d = 64'h77;
    #2;
    push(64'd0); chk("x7_wr_nocredit", 64'(l_rdy));
    tick();
    idle();
    l_e = 2'b11; l_a = {5'd7, 5'd7};
    #2;
    push(64'd1); chk("x7_lrdy_chain", 64'(l_rdy));
    l_e = 2'b01; l_a = 10'd7;
    w_e = 2'b01; w_a = 10'd7; w_d = 64'h70;
    tick();
    idle();
    rd(5'd7, 5'd0);
    w_e = 2'b01; w_a = 10'd7; w_d = 64'h71;
    #2;
    push(64'd1); chk("x7_cnt2_busy", 64'(r_busy));
    tick();
    rd(5'd7, 5'd0);
    w_e = 2'b01; w_a = 10'd7; w_d = 64'h72;
    #2;
    push(64'd0); chk("x7_cnt1_busy", 64'(r_busy));
    tick();
    idle();
    rd(5'd7, 5'd7);
    #2;
    push({2{32'h72}}); chk("x7_data", r_d);
    push(64'd0);       chk("x7_idle_busy", 64'(r_busy));
    push(64'd0);       chk("x7_err", 64'(err));
    tick();

    // dual writes to x9, highest port wins
    idle();
    l_e = 2'b11; l_a = {5'd9, 5'd9};
    #2;
    push(64'd3); chk("x9_lrdy", 64'(l_rdy));
    tick();
    idle();
    rd(5'd9, 5'd9);
    #2;
    push(64'd3); chk("x9_busy", 64'(r_busy));
    w_e = 2'b11; w_a = {5'd9, 5'd9};
    w_d = {32'h22, 32'h11};
    #1;
    push({2{32'h22}}); chk("x9_byp_d", r_d);
    push(64'd0);       chk("x9_byp_busy", 64'(r_busy));
    tick();
    idle();
    rd(5'd9, 5'd9);
    #2;
    push({2{32'h22}}); chk("x9_stored", r_d);
    push(64'd0);       chk("x9_busy_after", 64'(r_busy));
    push(64'd0);       chk("x9_err", 64'(err));
    tick();

    // x0 is immutable
    idle();
    rd(5'd0, 5'd0);
    w_e = 2'b01; w_a = 10'd0; w_d = 64'hFFFFFFFF;
    l_e = 2'b01; l_a = 10'd0;
    #2;
    push(64'd0); chk("x0_byp_d", r_d);
    push(64'd0); chk("x0_busy", 64'(r_busy));
    push(64'd3); chk("x0_lrdy", 64'(l_rdy));
    tick();
    idle();
    rd(5'd0, 5'd0);
    #2;
    push(64'd0); chk("x0_d", r_d);
    push(64'd0); chk("x0_busy2", 64'(r_busy));
    push(64'd0); chk("x0_err", 64'(err));
    tick();

    // underflow on x3
    idle();
    w_e = 2'b01; w_a = 10'd3; w_d = 64'h33;
    #2;
    push(64'd0); chk("x3_err_before", 64'(err));
    tick();
    idle();
    rd(5'd3, 5'd3);
    #2;
    push(64'd1);       chk("x3_err_set", 64'(err));
    push({2{32'h33}}); chk("x3_data", r_d);
    repeat (3) tick();
    push(64'd1); chk("x3_err_sticky", 64'(err));

    // reset mid-lock
    @(negedge clk);
    rst = 1'b0;
    #1;
    push(64'd0); chk("rst_clear_err", 64'(err));
    @(negedge clk);
    rst = 1'b1;
    tick();
    idle();
    l_e = 2'b01; l_a = 10'd4;
    tick();
    idle();
    rd(5'd4, 5'd4);
    #2;
    push(64'd3); chk("x4_busy", 64'(r_busy));
    rst = 1'b0;
    #1;
    push(64'd0); chk("x4_rst_busy", 64'(r_busy));
    push(64'd0); chk("x4_rst_err", 64'(err));
    @(negedge clk);
    rst = 1'b1;
    tick();
    w_e = 2'b01; w_a = 10'd4; w_d = 64'h44;
    tick();
    idle();
    rd(5'd4, 5'd4);
    #2;
    push(64'd1);       chk("x4_err", 64'(err));
    push({2{32'h44}}); chk("x4_data", r_d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
